trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
- Machine-mode trap sequencer in front of the CSR file.
- Arbitrates synchronous exceptions, pending interrupts and MRET. Latches mepc, mcause and mbadaddr, which drive the CSR file's trap inputs.
- Performs the mstatus read-modify-write through the CSR write port, then issues a single-cycle PC redirect to the fetch stage.
- Holds the pipeline with busy while a sequence is in flight.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0, value of redirect_pc and mepc after reset

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-high
exc_valid  in  1  exception request pulse from the pipeline
exc_cause  in  5  exception code
exc_pc  in  XLEN  PC of the faulting instruction
exc_badaddr  in  XLEN  faulting address or instruction
mret_valid  in  1  MRET retiring
irq_boundary  in  1  pipeline at an instruction boundary; an interrupt may be taken
irq_pc  in  XLEN  PC of the next instruction to execute
mstatus  in  XLEN  current mstatus from the CSR file
mie  in  XLEN  interrupt enable CSR
mip  in  XLEN  interrupt pending CSR
mtvec  in  XLEN  trap vector CSR
mcause  out  XLEN  latched cause, to the CSR file
mbadaddr  out  XLEN  latched bad address, to the CSR file
mepc  out  XLEN  latched return PC, to the CSR file
csr_addr  out  12  CSR write address
csr_wdata  out  XLEN  CSR write data
csr_we  out  1  CSR write strobe
redirect_valid  out  1  one-cycle fetch redirect
redirect_pc  out  XLEN  redirect target
busy  out  1  sequencer active; pipeline stalls

Behaviour:
Reset:
- State goes to IDLE.
- mcause=0, mbadaddr=0, mepc=RESET_PC, redirect_pc=RESET_PC.
- csr_addr=0, csr_wdata=0, csr_we=0, redirect_valid=0.
- An assertion in any state aborts the sequence; no partial CSR write survives.

mstatus fields: MIE bit 3, MPIE bit 7, MPP bits 12:11.

Interrupt eligibility:
- Condition: mstatus.MIE && (mip & mie & 32'h888) != 0.
- Priority: MEI (11) > MSI (3) > MTI (7).

FSM states: IDLE, SAVE, REDIR, MRET_WR, MRET_REDIR. busy = (state != IDLE), combinational.

IDLE (priority, exactly one event accepted per cycle):
1. exc_valid: latch mepc=exc_pc, mcause={1'b0, zero-extended exc_cause}, mbadaddr=exc_badaddr; go to SAVE.
2. mret_valid: go to MRET_WR.
3. Eligible interrupt && irq_boundary: latch mepc=irq_pc, mcause={1'b1, code}, mbadaddr=0; go to SAVE.

SAVE:
- csr_we=1, csr_addr=12'h300.
- csr_wdata = mstatus with MPIE<=MIE, MIE<=0, MPP<=2'b11.
- Go to REDIR.

REDIR:
- redirect_valid=1, redirect_pc=trap target.
- Go to IDLE.

MRET_WR:
- csr_we=1, csr_addr=12'h300.
- csr_wdata = mstatus with MIE<=MPIE, MPIE<=1, MPP<=2'b11.
- Go to MRET_REDIR.

MRET_REDIR:
- redirect_valid=1, redirect_pc=mepc.
- Go to IDLE.

Trap target: {mtvec[31:2], 2'b00}, with vectored adjustment under the optional feature.

Timing:
- Event accepted at cycle N: csr_we at N+1, redirect_valid at N+2, busy high N+1..N+2.
- csr_we and redirect_valid are registered single-cycle pulses, never high together.

Boundary conditions:
- Requests are ignored while busy; the pipeline must hold them.
- exc_valid and mret_valid together: the exception wins and the MRET is dropped.
- An interrupt pending without irq_boundary is not taken.
- mepc, mcause and mbadaddr hold their values until the next accepted trap. MRET does not modify them.

Optional Feature:
TRAP_VECTORED_EN
- Defined: if mtvec[1:0]==2'b01 and mcause[31]==1, trap target = {mtvec[31:2],2'b00} + (code<<2). Exceptions always use the base.
- Undefined: mtvec[1:0] is ignored; all traps go to the base (direct mode only).

Test Plan:
1. Exception: exc_valid, cause=2, pc=32'h100, badaddr=32'hDEAD, mstatus=32'h8, mtvec=32'h400 -> N+1: csr_we, addr 12'h300, wdata 32'h1880. N+2: redirect_pc=32'h400. mepc=32'h100, mcause=2, mbadaddr=32'hDEAD.
2. MRET: mret_valid, mepc=32'h100, mstatus=32'h1880 -> wdata 32'h1888, then redirect_pc=32'h100.
3. Interrupt priority: mip=mie=32'h888, mstatus=32'h8, irq_boundary, irq_pc=32'h204 -> mcause=32'h8000000B, mepc=32'h204. With MIE=0 or irq_boundary=0 -> no action.
4. Collision and busy: exc_valid and mret_valid in the same cycle -> exception sequence only. A second exc_valid during busy is ignored and mepc is unchanged.
5. Reset mid-sequence: resetn asserted in SAVE -> IDLE immediately, csr_we=0, mepc=RESET_PC, no redirect.
6. Vectored mode (TRAP_VECTORED_EN): mtvec=32'h401, MTI pending -> redirect_pc=32'h41C. Without the macro -> 32'h400.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer; define TRAP_VECTORED_EN for vectored interrupt targets
module trap_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            exc_valid,
  input  logic [4:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_badaddr,
  input  logic            mret_valid,
  input  logic            irq_boundary,
  input  logic [XLEN-1:0] irq_pc,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mip,
  input  logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mbadaddr,
  output logic [XLEN-1:0] mepc,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            csr_we,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);
  typedef enum logic [2:0] {IDLE, SAVE, REDIR, MRET_WR, MRET_REDIR} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] pend, base, target, save_val, mret_val, irq_cause;
  logic [4:0] code;
  logic irq_take, csr_wr;
  // interrupt arbitration, trap target and mstatus rewrite values
  always_comb begin
    pend = mip & mie & XLEN'(32'h888);
    irq_take = mstatus[3] && |pend && irq_boundary;
    code = pend[11] ? 5'd11 : pend[3] ? 5'd3 : 5'd7;
    irq_cause = {1'b1, {(XLEN-6){1'b0}}, code};
    base = mtvec & ~XLEN'(3);
`ifdef TRAP_VECTORED_EN
    target = (mtvec[1:0] == 2'b01 && mcause[XLEN-1]) ? base + {mcause[XLEN-3:0], 2'b00} : base;
`else
    target = base;
`endif
    save_val = (mstatus & ~XLEN'(32'h1888)) | XLEN'(32'h1800) | (mstatus[3] ? XLEN'(32'h80) : '0);
    mret_val = (mstatus & ~XLEN'(32'h1888)) | XLEN'(32'h1880) | (mstatus[7] ? XLEN'(32'h8) : '0);
    busy = state != IDLE;
  end
  // next-state: exception beats MRET beats interrupt; other states advance unconditionally
  always_comb begin
    state_n = IDLE;
    unique case (state)
      IDLE:    state_n = exc_valid ? SAVE : mret_valid ? MRET_WR : irq_take ? SAVE : IDLE;
      SAVE:    state_n = REDIR;
      MRET_WR: state_n = MRET_REDIR;
      default: state_n = IDLE;
    endcase
    csr_wr = state_n == SAVE || state_n == MRET_WR;
  end
  // state register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state <= IDLE;
    else state <= state_n;
  end
  // registered CSR write / redirect pulses and latched trap information
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      mcause <= '0;
      mbadaddr <= '0;
      mepc <= RESET_PC;
      redirect_pc <= RESET_PC;
      csr_addr <= '0;
      csr_wdata <= '0;
      csr_we <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      csr_we <= csr_wr;
      csr_addr <= csr_wr ? 12'h300 : 12'h000;
      csr_wdata <= state_n == SAVE ? save_val : state_n == MRET_WR ? mret_val : '0;
      redirect_valid <= state_n == REDIR || state_n == MRET_REDIR;
      if (state_n == REDIR) redirect_pc <= target;
      if (state_n == MRET_REDIR) redirect_pc <= mepc;
      if (state == IDLE && exc_valid) begin
        mepc <= exc_pc;
        mcause <= {{(XLEN-5){1'b0}}, exc_cause};
        mbadaddr <= exc_badaddr;
      end else if (state == IDLE && !mret_valid && irq_take) begin
        mepc <= irq_pc;
        mcause <= irq_cause;
        mbadaddr <= '0;
      end
    end
  end
endmodule
